// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register and a one-entry skid
// buffer that catches a word returning while decode is stalled.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ack,
   input  logic        stall,
   input  logic        redirect_en,
   input  logic [31:0] redirect_pc,
   output logic        ifid_valid,
   output logic [31:0] ifid_instr,
   output logic [31:0] ifid_pc4,
   output logic [5:0]  opcode,
   output logic [5:0]  func
);

   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [XLEN-1:0]   r_pc;
   logic              r_kill;
   logic [XLEN-1:0]   r_pend_pc;
   logic [XLEN-1:0]   r_buf_instr;
   logic [XLEN-1:0]   r_buf_pc4;
   logic              r_ifid_valid;
   logic [XLEN-1:0]   r_ifid_instr;
   logic [XLEN-1:0]   r_ifid_pc4;

   logic [XLEN-1:0]   w_redir_tgt;
   logic [XLEN-1:0]   w_pc4;
   logic              w_discard;
   logic              w_load_fetch;
   logic              w_load_hold;

   // Redirect target is always word aligned; pc+4 wraps naturally at 2^32.
   assign w_redir_tgt  = redirect_pc & ~XLEN'(32'h3);
   assign w_pc4        = r_pc + XLEN'(32'd4);
   assign w_discard    = imem_ack & (r_kill | redirect_en);
   assign w_load_fetch = (r_state == S_FETCH) & imem_ack & ~r_kill;
   assign w_load_hold  = (r_state == S_HOLD) & ~stall;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  w_state_nxt = S_FETCH;
         S_FETCH: begin
            if (imem_ack && !w_discard && stall) w_state_nxt = S_HOLD;
         end
         S_HOLD: begin
            if (redirect_en || !stall) w_state_nxt = S_FETCH;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Memory request outputs decoded from the state register.
   always_comb begin
      imem_req  = 1'b0;
      imem_addr = r_pc;
      if (r_state == S_FETCH) imem_req = 1'b1;
   end

   // PC, pending-redirect tracking and skid buffer.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc        <= RESET_PC;
         r_kill      <= 1'b0;
         r_pend_pc   <= '0;
         r_buf_instr <= '0;
         r_buf_pc4   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (redirect_en) r_pc <= w_redir_tgt;
            end
            S_FETCH: begin
               if (imem_ack) begin
                  if (w_discard) begin
                     r_pc   <= redirect_en ? w_redir_tgt : r_pend_pc;
                     r_kill <= 1'b0;
                  end else if (stall) begin
                     r_buf_instr <= imem_rdata;
                     r_buf_pc4   <= w_pc4;
                  end else begin
                     r_pc <= w_pc4;
                  end
               end else if (redirect_en) begin
                  // Request in flight cannot be cancelled; remember where to go.
                  r_kill    <= 1'b1;
                  r_pend_pc <= w_redir_tgt;
               end
            end
            S_HOLD: begin
               if (redirect_en)  r_pc <= w_redir_tgt;
               else if (!stall)  r_pc <= w_pc4;
            end
            default: r_pc <= r_pc;
         endcase
      end
   end

   // IF/ID register: redirect flush > stall hold > load > bubble.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ifid_valid <= 1'b0;
         r_ifid_instr <= '0;
         r_ifid_pc4   <= '0;
      end else if (redirect_en) begin
         r_ifid_valid <= 1'b0;
         r_ifid_instr <= '0;
      end else if (stall) begin
         r_ifid_valid <= r_ifid_valid;
      end else if (w_load_fetch) begin
         r_ifid_valid <= 1'b1;
         r_ifid_instr <= imem_rdata;
         r_ifid_pc4   <= w_pc4;
      end else if (w_load_hold) begin
         r_ifid_valid <= 1'b1;
         r_ifid_instr <= r_buf_instr;
         r_ifid_pc4   <= r_buf_pc4;
      end else begin
         r_ifid_valid <= 1'b0;
         r_ifid_instr <= '0;
      end
   end

   assign ifid_valid = r_ifid_valid;
   assign ifid_instr = r_ifid_instr;
   assign ifid_pc4   = r_ifid_pc4;
   assign opcode     = r_ifid_instr[31:26];
   assign func       = r_ifid_instr[5:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a scoreboard of expected IF/ID contents.
module tb_fetch_stage;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        redirect_en;
   logic [31:0] redirect_pc;

   logic        imem_req,   imem_req2;
   logic [31:0] imem_addr,  imem_addr2;
   logic [31:0] imem_rdata, imem_rdata2;
   logic        imem_ack,   imem_ack2;
   logic        ifid_valid, ifid_valid2;
   logic [31:0] ifid_instr, ifid_instr2;
   logic [31:0] ifid_pc4,   ifid_pc4_2;
   logic [5:0]  opcode,     opcode2;
   logic [5:0]  func,       func2;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc4;
   } exp_t;
   exp_t sb[$];

   fetch_stage dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .imem_ack(imem_ack),
      .stall(stall), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
      .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4),
      .opcode(opcode), .func(func)
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk(clk), .reset(reset),
      .imem_req(imem_req2), .imem_addr(imem_addr2),
      .imem_rdata(imem_rdata2), .imem_ack(imem_ack2),
      .stall(stall), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
      .ifid_valid(ifid_valid2), .ifid_instr(ifid_instr2), .ifid_pc4(ifid_pc4_2),
      .opcode(opcode2), .func(func2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic pop_check(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
      end else begin
         e = sb.pop_front();
         chk({tag, "_valid"}, 32'(ifid_valid), 32'd1);
         chk({tag, "_instr"}, ifid_instr, e.instr);
         chk({tag, "_pc4"},   ifid_pc4,   e.pc4);
      end
   endtask

   initial begin
      reset       = 1'b1;
      stall       = 1'b0;
      redirect_en = 1'b0;
      redirect_pc = '0;
      imem_ack    = 1'b0;
      imem_rdata  = '0;
      imem_ack2   = 1'b0;
      imem_rdata2 = '0;

      // Reset state
      step(); step();
      chk("rst_req",   32'(imem_req),   32'd0);
      chk("rst_valid", 32'(ifid_valid), 32'd0);
      chk("rst_instr", ifid_instr,      32'h0);
      chk("rst_pc4",   ifid_pc4,        32'h0);
      chk("rst_addr",  imem_addr,       32'h0040_0000);

      // Release reset with a spurious ack present while in IDLE (ignored)
      reset      = 1'b0;
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      step();
      imem_ack = 1'b0;
      chk("t1_req",         32'(imem_req),   32'd1);
      chk("t1_addr",        imem_addr,       32'h0040_0000);
      chk("idle_ack_valid", 32'(ifid_valid), 32'd0);

      // Test 1: ack one cycle after req
      imem_ack   = 1'b1;
      imem_rdata = 32'h2008_0005;
      sb.push_back('{instr: 32'h2008_0005, pc4: 32'h0040_0004});
      step();
      imem_ack = 1'b0;
      pop_check("t1_ifid");
      chk("t1_opcode",    32'(opcode),   32'h08);
      chk("t1_next_addr", imem_addr,     32'h0040_0004);
      chk("t1_next_req",  32'(imem_req), 32'd1);

      // Test 2: ack during stall goes to skid buffer, stall held 3 cycles
      imem_ack   = 1'b1;
      imem_rdata = 32'h2129_0001;
      stall      = 1'b1;
      sb.push_back('{instr: 32'h2129_0001, pc4: 32'h0040_0008});
      for (int i = 0; i < 3; i++) begin
         step();
         imem_ack = 1'b0;
         chk("t2_hold_req",   32'(imem_req),   32'd0);
         chk("t2_hold_valid", 32'(ifid_valid), 32'd1);
         chk("t2_hold_instr", ifid_instr,      32'h2008_0005);
      end
      stall = 1'b0;
      step();
      pop_check("t2_release");
      chk("t2_req",  32'(imem_req), 32'd1);
      chk("t2_addr", imem_addr,     32'h0040_0008);

      // Test 3: redirect while waiting for a 3-cycle ack
      redirect_en = 1'b1;
      redirect_pc = 32'h0040_0100;
      step();
      redirect_en = 1'b0;
      chk("t3_wait1_addr",  imem_addr,       32'h0040_0008);
      chk("t3_wait1_valid", 32'(ifid_valid), 32'd0);
      chk("t3_wait1_instr", ifid_instr,      32'h0);
      step();
      chk("t3_wait2_addr",  imem_addr,       32'h0040_0008);
      chk("t3_wait2_req",   32'(imem_req),   32'd1);
      imem_ack   = 1'b1;
      imem_rdata = 32'hBAD0_BAD0;
      step();
      imem_ack = 1'b0;
      chk("t3_drop_valid", 32'(ifid_valid), 32'd0);
      chk("t3_new_addr",   imem_addr,       32'h0040_0100);
      chk("t3_new_req",    32'(imem_req),   32'd1);

      // Test 4: load a word, then stall into HOLD, then redirect+stall
      imem_ack   = 1'b1;
      imem_rdata = 32'h8D09_0000;
      sb.push_back('{instr: 32'h8D09_0000, pc4: 32'h0040_0104});
      step();
      pop_check("t4_pre");
      imem_rdata = 32'h1234_5678;
      stall      = 1'b1;
      step();
      imem_ack = 1'b0;
      chk("t4_hold_req",   32'(imem_req), 32'd0);
      chk("t4_hold_instr", ifid_instr,    32'h8D09_0000);
      redirect_en = 1'b1;
      redirect_pc = 32'h0040_0203;
      step();
      redirect_en = 1'b0;
      stall       = 1'b0;
      chk("t4_flush_valid", 32'(ifid_valid), 32'd0);
      chk("t4_flush_instr", ifid_instr,      32'h0);
      chk("t4_redir_req",   32'(imem_req),   32'd1);
      chk("t4_redir_addr",  imem_addr,       32'h0040_0200);

      // Plain fetch at the redirect target, R-type word for func decode
      imem_ack   = 1'b1;
      imem_rdata = 32'h0085_1020;
      sb.push_back('{instr: 32'h0085_1020, pc4: 32'h0040_0204});
      step();
      imem_ack = 1'b0;
      pop_check("t4_after");
      chk("t4_func",   32'(func),   32'h20);
      chk("t4_opcode", 32'(opcode), 32'h00);

      // Test 6: reset while a request is outstanding
      step();
      chk("t6_wait_req", 32'(imem_req), 32'd1);
      reset = 1'b1;
      step();
      chk("t6_rst_req",   32'(imem_req),   32'd0);
      chk("t6_rst_valid", 32'(ifid_valid), 32'd0);
      chk("t6_rst_pc",    imem_addr,       32'h0040_0000);
      reset = 1'b0;
      step();
      chk("t6_first_req",  32'(imem_req), 32'd1);
      chk("t6_first_addr", imem_addr,     32'h0040_0000);

      // Test 5: PC wrap on the second instance
      chk("t5_addr0", imem_addr2, 32'hFFFF_FFFC);
      imem_ack2   = 1'b1;
      imem_rdata2 = 32'h0C10_0000;
      step();
      imem_ack2 = 1'b0;
      chk("t5_valid",  32'(ifid_valid2), 32'd1);
      chk("t5_instr",  ifid_instr2,      32'h0C10_0000);
      chk("t5_pc4",    ifid_pc4_2,       32'h0000_0000);
      chk("t5_addr1",  imem_addr2,       32'h0000_0000);
      chk("t5_req1",   32'(imem_req2),   32'd1);

      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
